// File: rtl/simmem_lane_arbiter.sv
// Round-robin arbiter funnelling NUM_LANES request lanes into one memory port and
// routing in-order responses back via a lane-ID FIFO. Optional macro: SIMMEM_ARB_STATS_EN.
`ifndef SIMMEM_DATA_WIDTH
`define SIMMEM_DATA_WIDTH 32
`endif
`ifndef SIMMEM_LOGSIZE_WIDTH
`define SIMMEM_LOGSIZE_WIDTH 3
`endif
`ifndef MAX_NUM_LANES
`define MAX_NUM_LANES 16
`endif

module simmem_lane_arbiter #(
    parameter int NUM_LANES       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NUM_LANES-1:0]                            a_valid,
    output logic [NUM_LANES-1:0]                            a_ready,
    input  logic [`SIMMEM_DATA_WIDTH*NUM_LANES-1:0]         a_address,
    input  logic [NUM_LANES-1:0]                            a_is_store,
    input  logic [`SIMMEM_LOGSIZE_WIDTH*NUM_LANES-1:0]      a_size,
    input  logic [`SIMMEM_DATA_WIDTH*NUM_LANES-1:0]         a_data,
    output logic [NUM_LANES-1:0]                            d_valid,
    input  logic [NUM_LANES-1:0]                            d_ready,
    output logic [NUM_LANES-1:0]                            d_is_store,
    output logic [`SIMMEM_LOGSIZE_WIDTH*NUM_LANES-1:0]      d_size,
    output logic                                            mem_a_valid,
    input  logic                                            mem_a_ready,
    output logic [`SIMMEM_DATA_WIDTH-1:0]                   mem_a_address,
    output logic                                            mem_a_is_store,
    output logic [`SIMMEM_LOGSIZE_WIDTH-1:0]                mem_a_size,
    output logic [`SIMMEM_DATA_WIDTH-1:0]                   mem_a_data,
    input  logic                                            mem_d_valid,
    output logic                                            mem_d_ready,
    input  logic                                            mem_d_is_store,
    input  logic [`SIMMEM_LOGSIZE_WIDTH-1:0]                mem_d_size,
    output logic [$clog2(MAX_OUTSTANDING):0]                outstanding,
    output logic                                            protocol_error
`ifdef SIMMEM_ARB_STATS_EN
    ,
    output logic [31:0]                                     stall_cycles
`endif
);

    localparam int DW = `SIMMEM_DATA_WIDTH;
    localparam int SW = `SIMMEM_LOGSIZE_WIDTH;
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_OUTSTANDING);
    localparam logic [LW-1:0] LAST_LANE  = LW'(NUM_LANES - 1);

    logic [DW-1:0] lane_address [NUM_LANES];
    logic [DW-1:0] lane_data    [NUM_LANES];
    logic [SW-1:0] lane_size    [NUM_LANES];

    logic          hold_valid_reg;
    logic [DW-1:0] hold_address_reg;
    logic [DW-1:0] hold_data_reg;
    logic [SW-1:0] hold_size_reg;
    logic          hold_is_store_reg;

    logic [LW-1:0] rr_ptr_reg;
    logic [LW-1:0] id_fifo [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          protocol_error_reg;

    logic          can_load;
    logic          grant_found;
    logic [LW-1:0] grant_idx;
    logic [LW-1:0] search_idx;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [LW-1:0] head;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_address[gi] = a_address[gi*DW +: DW];
            assign lane_data[gi]    = a_data[gi*DW +: DW];
            assign lane_size[gi]    = a_size[gi*SW +: SW];
            // Async reset also gates the handshakes so nothing is offered while it is held.
            assign a_ready[gi]      = !reset && can_load && grant_found && (grant_idx == LW'(gi));
            assign d_valid[gi]      = mem_d_valid && !fifo_empty && (head == LW'(gi));
            assign d_is_store[gi]   = mem_d_is_store;
            assign d_size[gi*SW +: SW] = mem_d_size;
        end
    endgenerate

    // First valid lane at or after rr_ptr, wrapping modulo NUM_LANES.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            search_idx = LW'((int'(rr_ptr_reg) + i) % NUM_LANES);
            if (!grant_found && a_valid[search_idx]) begin
                grant_found = 1'b1;
                grant_idx   = search_idx;
            end
        end
    end

    assign fifo_empty  = (count_reg == '0);
    assign head        = id_fifo[rd_ptr_reg];
    assign can_load    = (!hold_valid_reg || mem_a_ready) && (count_reg < FULL_COUNT);
    assign push        = !reset && can_load && grant_found;
    assign mem_d_ready = !reset && !fifo_empty && d_ready[head];
    assign pop         = mem_d_valid && mem_d_ready;

    assign mem_a_valid    = hold_valid_reg;
    assign mem_a_address  = hold_address_reg;
    assign mem_a_data     = hold_data_reg;
    assign mem_a_size     = hold_size_reg;
    assign mem_a_is_store = hold_is_store_reg;
    assign outstanding    = count_reg;
    assign protocol_error = protocol_error_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid_reg     <= 1'b0;
            hold_address_reg   <= '0;
            hold_data_reg      <= '0;
            hold_size_reg      <= '0;
            hold_is_store_reg  <= 1'b0;
            rr_ptr_reg         <= '0;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            protocol_error_reg <= 1'b0;
        end else begin
            if (push) begin
                hold_valid_reg    <= 1'b1;
                hold_address_reg  <= lane_address[grant_idx];
                hold_data_reg     <= lane_data[grant_idx];
                hold_size_reg     <= lane_size[grant_idx];
                hold_is_store_reg <= a_is_store[grant_idx];
                rr_ptr_reg        <= (grant_idx == LAST_LANE) ? '0 : grant_idx + LW'(1);
                wr_ptr_reg        <= wr_ptr_reg + PW'(1);
            end else if (mem_a_ready) begin
                hold_valid_reg <= 1'b0;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
            if (mem_d_valid && fifo_empty) begin
                protocol_error_reg <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clock) begin
        if (push) begin
            id_fifo[wr_ptr_reg] <= grant_idx;
        end
    end

`ifdef SIMMEM_ARB_STATS_EN
    logic [31:0] stall_cycles_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_reg <= '0;
        end else if ((|a_valid) && !(|a_ready) && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_simmem_lane_arbiter.sv
// Directed self-checking bench for simmem_lane_arbiter (NUM_LANES=4, MAX_OUTSTANDING=8).
`ifndef SIMMEM_DATA_WIDTH
`define SIMMEM_DATA_WIDTH 32
`endif
`ifndef SIMMEM_LOGSIZE_WIDTH
`define SIMMEM_LOGSIZE_WIDTH 3
`endif

module tb_simmem_lane_arbiter;
    localparam int NL = 4;
    localparam int MO = 8;
    localparam int DW = `SIMMEM_DATA_WIDTH;
    localparam int SW = `SIMMEM_LOGSIZE_WIDTH;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NL-1:0]      a_valid;
    logic [NL-1:0]      a_ready;
    logic [DW*NL-1:0]   a_address;
    logic [NL-1:0]      a_is_store;
    logic [SW*NL-1:0]   a_size;
    logic [DW*NL-1:0]   a_data;
    logic [NL-1:0]      d_valid;
    logic [NL-1:0]      d_ready;
    logic [NL-1:0]      d_is_store;
    logic [SW*NL-1:0]   d_size;
    logic               mem_a_valid;
    logic               mem_a_ready;
    logic [DW-1:0]      mem_a_address;
    logic               mem_a_is_store;
    logic [SW-1:0]      mem_a_size;
    logic [DW-1:0]      mem_a_data;
    logic               mem_d_valid;
    logic               mem_d_ready;
    logic               mem_d_is_store;
    logic [SW-1:0]      mem_d_size;
    logic [$clog2(MO):0] outstanding;
    logic               protocol_error;
`ifdef SIMMEM_ARB_STATS_EN
    logic [31:0]        stall_cycles;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    simmem_lane_arbiter #(.NUM_LANES(NL), .MAX_OUTSTANDING(MO)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_address(a_address),
        .a_is_store(a_is_store), .a_size(a_size), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_is_store(d_is_store), .d_size(d_size),
        .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready), .mem_a_address(mem_a_address),
        .mem_a_is_store(mem_a_is_store), .mem_a_size(mem_a_size), .mem_a_data(mem_a_data),
        .mem_d_valid(mem_d_valid), .mem_d_ready(mem_d_ready),
        .mem_d_is_store(mem_d_is_store), .mem_d_size(mem_d_size),
        .outstanding(outstanding), .protocol_error(protocol_error)
`ifdef SIMMEM_ARB_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    function automatic logic [DW-1:0] lane_addr(input int g);
        return DW'(32'h1000 + g * 16);
    endfunction

    function automatic logic [DW-1:0] lane_data(input int g);
        return DW'(32'hD000 + g);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic init_lanes();
        for (int g = 0; g < NL; g++) begin
            a_address[g*DW +: DW] = lane_addr(g);
            a_data[g*DW +: DW]    = lane_data(g);
            a_size[g*SW +: SW]    = SW'(g);
            a_is_store[g]         = g[0];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_valid = '0; mem_a_ready = 1'b0; mem_d_valid = 1'b0;
        mem_d_is_store = 1'b0; mem_d_size = '0; d_ready = '1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        init_lanes();
        reset = 1'b1;
        a_valid = '1; mem_a_ready = 1'b1; mem_d_valid = 1'b1;
        mem_d_is_store = 1'b0; mem_d_size = '0; d_ready = '1;
        #12;
        checks++; if (a_ready !== 4'b0000) $display("FAIL reset_a_ready got=%b exp=0000", a_ready); else passed++;
        checks++; if (mem_a_valid !== 1'b0) $display("FAIL reset_mem_a_valid got=%b exp=0", mem_a_valid); else passed++;
        checks++; if (d_valid !== 4'b0000) $display("FAIL reset_d_valid got=%b exp=0000", d_valid); else passed++;
        checks++; if (mem_d_ready !== 1'b0) $display("FAIL reset_mem_d_ready got=%b exp=0", mem_d_ready); else passed++;
        checks++; if (outstanding !== 4'd0) $display("FAIL reset_outstanding got=%0d exp=0", outstanding); else passed++;
        checks++; if (protocol_error !== 1'b0) $display("FAIL reset_protocol_error got=%b exp=0", protocol_error); else passed++;
        do_reset();
    endtask

    task automatic test_round_robin();
        int exp_lane [5] = '{0, 1, 2, 3, 0};
        do_reset();
        mem_a_ready = 1'b1;
        a_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (a_ready !== 4'(1 << exp_lane[k])) $display("FAIL rr_grant k=%0d got=%b exp_lane=%0d", k, a_ready, exp_lane[k]); else passed++;
            step();
            if (k == 4) a_valid = '0;
            checks++; if (mem_a_valid !== 1'b1 || mem_a_address !== lane_addr(exp_lane[k]))
                $display("FAIL rr_address k=%0d got=%h/%b exp=%h/1", k, mem_a_address, mem_a_valid, lane_addr(exp_lane[k]));
            else passed++;
        end
        checks++; if (mem_a_data !== lane_data(0) || mem_a_size !== SW'(0)) $display("FAIL rr_fields got=%h/%0d exp=%h/0", mem_a_data, mem_a_size, lane_data(0)); else passed++;
        checks++; if (outstanding !== 4'd5) $display("FAIL rr_outstanding got=%0d exp=5", outstanding); else passed++;
    endtask

    task automatic test_hold_stall();
        do_reset();
        a_valid = 4'b0100;
        mem_a_ready = 1'b0;
        #1;
        checks++; if (a_ready !== 4'b0100) $display("FAIL stall_first_grant got=%b exp=0100", a_ready); else passed++;
        step();
        for (int k = 0; k < 3; k++) begin
            checks++; if (a_ready !== 4'b0000 || mem_a_valid !== 1'b1 || mem_a_address !== lane_addr(2) || mem_a_is_store !== 1'b0)
                $display("FAIL stall_hold k=%0d got=%b/%b/%h exp=0000/1/%h", k, a_ready, mem_a_valid, mem_a_address, lane_addr(2));
            else passed++;
            step();
        end
        mem_a_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 4'b0100) $display("FAIL stall_release got=%b exp=0100", a_ready); else passed++;
        step();
        a_valid = '0;
        checks++; if (outstanding !== 4'd2 || mem_a_valid !== 1'b1) $display("FAIL stall_second got=%0d/%b exp=2/1", outstanding, mem_a_valid); else passed++;
        step();
        checks++; if (mem_a_valid !== 1'b0) $display("FAIL stall_drain got=%b exp=0", mem_a_valid); else passed++;
    endtask

    task automatic test_fifo_full();
        do_reset();
        a_valid = 4'b1111;
        mem_a_ready = 1'b1;
        repeat (8) step();
        checks++; if (outstanding !== 4'd8 || a_ready !== 4'b0000) $display("FAIL full_block got=%0d/%b exp=8/0000", outstanding, a_ready); else passed++;
        mem_d_valid = 1'b1;
        d_ready = 4'b1111;
        #1;
        checks++; if (d_valid !== 4'b0001 || mem_d_ready !== 1'b1 || a_ready !== 4'b0000)
            $display("FAIL full_pop_cycle got=%b/%b/%b exp=0001/1/0000", d_valid, mem_d_ready, a_ready);
        else passed++;
        step();
        mem_d_valid = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd7 || a_ready !== 4'b0001) $display("FAIL full_resume got=%0d/%b exp=7/0001", outstanding, a_ready); else passed++;
        step();
        checks++; if (outstanding !== 4'd8 || a_ready !== 4'b0000) $display("FAIL full_refill got=%0d/%b exp=8/0000", outstanding, a_ready); else passed++;
        a_valid = '0;
    endtask

    task automatic test_response_routing();
        do_reset();
        mem_a_ready = 1'b1;
        a_valid = 4'b0010;
        #1;
        checks++; if (a_ready !== 4'b0010) $display("FAIL route_grant1 got=%b exp=0010", a_ready); else passed++;
        step();
        a_valid = 4'b1000;
        #1;
        checks++; if (a_ready !== 4'b1000) $display("FAIL route_grant3 got=%b exp=1000", a_ready); else passed++;
        step();
        a_valid = 4'b0001;
        #1;
        checks++; if (a_ready !== 4'b0001) $display("FAIL route_grant0 got=%b exp=0001", a_ready); else passed++;
        step();
        a_valid = '0;
        checks++; if (outstanding !== 4'd3) $display("FAIL route_outstanding got=%0d exp=3", outstanding); else passed++;
        mem_d_valid = 1'b1;
        mem_d_is_store = 1'b1;
        mem_d_size = SW'(2);
        d_ready = 4'b0111;
        #1;
        checks++; if (d_valid !== 4'b0010 || mem_d_ready !== 1'b1) $display("FAIL route_lane1 got=%b/%b exp=0010/1", d_valid, mem_d_ready); else passed++;
        checks++; if (d_is_store !== 4'b1111 || d_size !== {NL{SW'(2)}}) $display("FAIL route_broadcast got=%b/%h exp=1111/%h", d_is_store, d_size, {NL{SW'(2)}}); else passed++;
        step();
        checks++; if (d_valid !== 4'b1000 || mem_d_ready !== 1'b0) $display("FAIL route_lane3_stall got=%b/%b exp=1000/0", d_valid, mem_d_ready); else passed++;
        step();
        checks++; if (outstanding !== 4'd2) $display("FAIL route_stall_hold got=%0d exp=2", outstanding); else passed++;
        d_ready = 4'b1111;
        #1;
        checks++; if (mem_d_ready !== 1'b1) $display("FAIL route_lane3_go got=%b exp=1", mem_d_ready); else passed++;
        step();
        checks++; if (d_valid !== 4'b0001) $display("FAIL route_lane0 got=%b exp=0001", d_valid); else passed++;
        step();
        mem_d_valid = 1'b0;
        checks++; if (outstanding !== 4'd0 || protocol_error !== 1'b0) $display("FAIL route_drained got=%0d/%b exp=0/0", outstanding, protocol_error); else passed++;
    endtask

    task automatic test_protocol_error();
        do_reset();
        mem_d_valid = 1'b1;
        #1;
        checks++; if (mem_d_ready !== 1'b0 || d_valid !== 4'b0000) $display("FAIL perr_no_route got=%b/%b exp=0/0000", mem_d_ready, d_valid); else passed++;
        step();
        mem_d_valid = 1'b0;
        checks++; if (protocol_error !== 1'b1) $display("FAIL perr_set got=%b exp=1", protocol_error); else passed++;
        repeat (2) step();
        checks++; if (protocol_error !== 1'b1) $display("FAIL perr_sticky got=%b exp=1", protocol_error); else passed++;
        a_valid = 4'b1111;
        mem_a_ready = 1'b1;
        repeat (5) step();
        a_valid = '0;
        checks++; if (outstanding !== 4'd5) $display("FAIL perr_outstanding5 got=%0d exp=5", outstanding); else passed++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (outstanding !== 4'd0 || protocol_error !== 1'b0 || mem_a_valid !== 1'b0)
            $display("FAIL midreset_clear got=%0d/%b/%b exp=0/0/0", outstanding, protocol_error, mem_a_valid);
        else passed++;
        step();
        reset = 1'b0;
        mem_d_valid = 1'b1;
        d_ready = 4'b1111;
        #1;
        checks++; if (d_valid !== 4'b0000 || mem_d_ready !== 1'b0) $display("FAIL midreset_no_route got=%b/%b exp=0000/0", d_valid, mem_d_ready); else passed++;
        step();
        mem_d_valid = 1'b0;
    endtask

`ifdef SIMMEM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        a_valid = 4'b1111;
        mem_a_ready = 1'b1;
        repeat (8) step();
        checks++; if (stall_cycles !== 32'd0) $display("FAIL stats_no_stall got=%0d exp=0", stall_cycles); else passed++;
        repeat (10) step();
        checks++; if (stall_cycles !== 32'd10) $display("FAIL stats_ten got=%0d exp=10", stall_cycles); else passed++;
        a_valid = '0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_hold_stall();
        test_fifo_full();
        test_response_routing();
        test_protocol_error();
`ifdef SIMMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
